qspi_ram_reader: RTL
====================

# qspi_ram_reader

Burst-read controller for the external QSPI PSRAM on the TinyTapeout pins. It sits between the core's memory request port and the RAM pins: `ram_clk`, `ram_csn` and the four bidirectional `uio[3:0]` lines. It accepts an address and a byte count, issues an EBh fast-quad-read, and streams the returned bytes to the core, one valid pulse per byte. The top level connects `io_out`/`io_oe` to the `uio` output and enable pins and `io_in` to the `uio` input pins.

## Interface
- `DUMMY_CYCLES`, default 6: RAM clocks between the last address nibble and the first data nibble.
- `CS_HIGH_CYCLES`, default 2: minimum `clk` cycles `ram_csn` stays high between bursts (range 1..15).
- `clk`  in  1  system clock; the RAM clock is `clk`/2.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  read request.
- `req_ready`  out  1  controller idle; a request is accepted when `req_valid && req_ready`.
- `req_addr`  in  24  byte address.
- `req_len`  in  8  burst length in bytes; 0 means 256.
- `rd_valid`  out  1  one-cycle pulse, `rd_data` valid; no backpressure.
- `rd_data`  out  8  returned byte.
- `ram_clk`  out  1  RAM SPI clock.
- `ram_csn`  out  1  RAM chip select, active-low.
- `io_out`  out  4  values driven on `uio[3:0]`.
- `io_oe`  out  4  per-line output enable.
- `io_in`  in  4  values sampled from `uio[3:0]`.

## Operation
- Reset values (applied asynchronously while `rst_n`=0): `ram_csn`=1, `ram_clk`=0, `io_oe`=0000, `io_out`=0000, `rd_valid`=0, `rd_data`=00h, `req_ready`=1.
- A reset asserted mid-burst raises `ram_csn` immediately and abandons the burst. No partial byte is emitted.
- `req_addr` and `req_len` are latched at acceptance. Later changes on those inputs are ignored.
- States: IDLE → CMD → ADDR → DUMMY → DATA → GAP → IDLE.
  - IDLE: `req_ready`=1. On acceptance, go to CMD.
  - CMD: 8 RAM clocks. `io_oe`=0001. `io0` carries EBh MSB-first (1,1,1,0,1,0,1,1). `io_out[3:1]`=000.
  - ADDR: 6 RAM clocks. `io_oe`=1111. One nibble per clock, address bits [23:20] first.
  - DUMMY: `DUMMY_CYCLES` RAM clocks. `io_oe`=0000.
  - DATA: 2 RAM clocks per byte. `io_oe`=0000. The high nibble is sampled first. After the last byte, go to GAP.
  - GAP: `ram_csn`=1 for `CS_HIGH_CYCLES` cycles, then IDLE.
- Remaining-byte counter is 9 bits: loaded with `req_len`, or 256 when `req_len`=0, and decremented per byte.
- Address wrap inside the RAM is the RAM's concern. The controller never splits a burst.
- `req_ready`=0 in every state except IDLE. A `req_valid` asserted during a burst is held off and is not lost; it is accepted on the first IDLE cycle.

## Timing
- RAM clock phase: `ram_clk` is low for one `clk` cycle, then high for one `clk` cycle.
- `io_out` changes only on the edge where `ram_clk` goes low.
- `io_in` is sampled on the edge where `ram_clk` goes high→low, i.e. at the end of the high phase.
- Acceptance at cycle T (edge where `req_valid && req_ready`):
  - T+1: `ram_csn`=0, `ram_clk`=0, `io0`=1 (cmd bit 7).
  - First `rd_valid` at T+1+2·(8+6+`DUMMY_CYCLES`+2) = T+45 with default parameters.
  - Each later byte: `rd_valid` exactly 4 cycles after the previous one.
- On the cycle of the last `rd_valid`:
  - `ram_csn`=1, `ram_clk`=0, `io_oe`=0000.
  - `req_ready` rises `CS_HIGH_CYCLES` cycles later (T_last+2 with the default).
- Back-to-back requests: minimum distance between `ram_csn` rising and falling is `CS_HIGH_CYCLES`+1 cycles.
- `rd_data` holds its value between pulses.

## Test plan
- Reset: drive `rst_n`=0 with random inputs → every output at its reset value. Release; `req_ready`=1 on the first cycle.
- Single byte: `req_addr`=123456h, `req_len`=1, RAM model returns A5h.
  - `io0` serial EBh, then `io_out` nibbles 1,2,3,4,5,6 with `io_oe`=1111.
  - `rd_valid` at T+45 with `rd_data`=A5h; `ram_csn`=1 at that cycle.
  - `req_ready`=1 at T+47.
- Burst: `req_len`=4, model returns 10h,32h,54h,76h → four pulses at T+45, +49, +53, +57 with those values in order.
- Length 0: `req_len`=0 → exactly 256 pulses. The model's incrementing pattern arrives intact, with no `ram_csn` rise mid-burst.
- Reset mid-burst: assert `rst_n`=0 after the 2nd byte of an 8-byte burst.
  - `ram_csn`=1 immediately; no further `rd_valid`.
  - A new request after release completes normally.
- Held request: `req_valid` held high throughout a 2-byte burst with new address 00ABCDh.
  - Second request accepted on the first IDLE cycle.
  - Address nibbles 0,0,A,B,C,D seen on `io_out`.

Source files
------------

// File: rtl/qspi_ram_reader.sv
// rtl/qspi_ram_reader.sv - QSPI PSRAM burst reader issuing EBh quad reads and streaming bytes
module qspi_ram_reader #(
    parameter int DUMMY_CYCLES   = 6,
    parameter int CS_HIGH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    input  logic [7:0]  req_len,
    output logic        rd_valid,
    output logic [7:0]  rd_data,
    output logic        ram_clk,
    output logic        ram_csn,
    output logic [3:0]  io_out,
    output logic [3:0]  io_oe,
    input  logic [3:0]  io_in
);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_GAP
    } state_t;

    localparam logic [7:0] CMD_EB = 8'hEB;

    state_t      state;
    logic [7:0]  cnt;
    logic [23:0] addr_sr;
    logic [8:0]  remaining;
    logic [3:0]  hi_nib;
    logic [3:0]  gap_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            addr_sr   <= '0;
            remaining <= '0;
            hi_nib    <= '0;
            gap_cnt   <= '0;
            req_ready <= 1'b1;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            ram_clk   <= 1'b0;
            ram_csn   <= 1'b1;
            io_out    <= '0;
            io_oe     <= '0;
        end else begin
            rd_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        state     <= S_CMD;
                        req_ready <= 1'b0;
                        ram_csn   <= 1'b0;
                        ram_clk   <= 1'b0;
                        io_oe     <= 4'b0001;
                        io_out    <= {3'b000, CMD_EB[7]};
                        cnt       <= '0;
                        addr_sr   <= req_addr;
                        remaining <= (req_len == 8'd0) ? 9'd256 : {1'b0, req_len};
                    end
                end
                S_GAP: begin
                    if (gap_cnt == 4'd0) begin
                        state     <= S_IDLE;
                        req_ready <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
                default: begin
                    if (!ram_clk) begin
                        ram_clk <= 1'b1;
                    end else begin
                        // End of a RAM clock: io_out advances and io_in is sampled here
                        ram_clk <= 1'b0;
                        cnt     <= cnt + 8'd1;
                        case (state)
                            S_CMD: begin
                                if (cnt == 8'd7) begin
                                    state   <= S_ADDR;
                                    cnt     <= '0;
                                    io_oe   <= 4'b1111;
                                    io_out  <= addr_sr[23:20];
                                    addr_sr <= {addr_sr[19:0], 4'b0000};
                                end else begin
                                    io_out <= {3'b000, CMD_EB[3'd6 - cnt[2:0]]};
                                end
                            end
                            S_ADDR: begin
                                if (cnt == 8'd5) begin
                                    state  <= (DUMMY_CYCLES == 0) ? S_DATA : S_DUMMY;
                                    cnt    <= '0;
                                    io_oe  <= 4'b0000;
                                    io_out <= 4'b0000;
                                end else begin
                                    io_out  <= addr_sr[23:20];
                                    addr_sr <= {addr_sr[19:0], 4'b0000};
                                end
                            end
                            S_DUMMY: begin
                                if (cnt == 8'(DUMMY_CYCLES - 1)) begin
                                    state <= S_DATA;
                                    cnt   <= '0;
                                end
                            end
                            S_DATA: begin
                                if (!cnt[0]) begin
                                    hi_nib <= io_in;
                                end else begin
                                    cnt       <= '0;
                                    rd_data   <= {hi_nib, io_in};
                                    rd_valid  <= 1'b1;
                                    remaining <= remaining - 9'd1;
                                    if (remaining == 9'd1) begin
                                        state   <= S_GAP;
                                        ram_csn <= 1'b1;
                                        gap_cnt <= 4'(CS_HIGH_CYCLES - 1);
                                    end
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule
